// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: serialises instruction-fetch and load/store accesses
// onto the single-ported unified memory. One access at a time, fixed
// WAIT_CYCLES enable window, one-cycle acknowledge to the winner, and
// round-robin between the two requesters on contention.
module mem_bus_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  // fetch requester
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic [DW-1:0] f_rdata,
  output logic          f_ack,
  // data requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  // memory bus
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int            CW       = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_data_q, last_data_d;  // 1 = data path owned the last access
  logic [1:0]    grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          f_win, d_win;

  // Arbitration: a lone requester wins; on contention the one that did not
  // own the previous access wins.
  always_comb begin
    f_win = 1'b0;
    d_win = 1'b0;
    if (f_req && d_req) begin
      f_win = last_data_q;
      d_win = !last_data_q;
    end else begin
      f_win = f_req;
      d_win = d_req;
    end
  end

  // Next-state logic: latch the winner's request, count the access window,
  // capture read data on the final enable cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (f_win) begin
          state_d     = ACCESS;
          grant_d     = 2'b01;
          last_data_d = 1'b0;
          addr_d      = f_addr;
          we_d        = 1'b0;
          cnt_d       = '0;
        end else if (d_win) begin
          state_d     = ACCESS;
          grant_d     = 2'b10;
          last_data_d = 1'b1;
          addr_d      = d_addr;
          wdata_d     = d_wdata;
          we_d        = d_we;
          cnt_d       = '0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (!we_q) begin
            if (grant_q[0]) f_rdata_d = mem_rdata;
            else            d_rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b1;
      grant_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Outputs decode directly from registered state, so reset clears them
  // without waiting for a clock edge.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign f_ack     = (state_q == DONE) && grant_q[0];
  assign d_ack     = (state_q == DONE) && grant_q[1];
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized
// request traffic, checked against a transaction-level model of the
// arbitration rules and a reference copy of memory contents.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, f_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
  logic [AW-1:0] f_addr, d_addr, mem_addr;
  logic [DW-1:0] f_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [1:0]    grant;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc++;

  // Initial memory image shared by the memory and the reference copy.
  function automatic logic [15:0] init_val(input logic [11:0] a);
    if (a == 12'h040)      return 16'hBEEF;
    else if (a == 12'h100) return 16'h1234;
    else                   return {a, 4'h0} ^ 16'h5A5A;
  endfunction

  // Memory: 4K words, combinational read, write on the clock edge.
  logic [15:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_val(12'(i));
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[11:0]];

  // Reference model state
  logic [15:0] ref_mem [0:4095];
  bit          m_last_data;
  logic [15:0] exp_f, exp_d;
  int unsigned last_ack_cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rdata();
    chk("f_rdata", f_rdata, exp_f);
    chk("d_rdata", d_rdata, exp_d);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_grant"},  grant,  0);
    chk({tag, "_busy"},   busy,   0);
    chk({tag, "_f_ack"},  f_ack,  0);
    chk({tag, "_d_ack"},  d_ack,  0);
  endtask

  // Round-robin rule: alone wins; both -> whoever was not served last.
  function automatic bit fetch_wins(input bit f, input bit d);
    if (f && d) return m_last_data;
    return f;
  endfunction

  // Called at the falling edge of an IDLE cycle with requests already set.
  // Follows one access through ACCESS, DONE and the next IDLE cycle.
  // mode: 0 plain, 1 scramble winner inputs mid-access, 2 move address to
  // 0x0300 and drop the request mid-access.
  task automatic expect_access(input bit fw, input logic [15:0] a,
                               input logic [15:0] wd, input bit we, input int mode);
    logic [1:0] g;
    g = fw ? 2'b01 : 2'b10;
    m_last_data = !fw;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      chk("acc_grant", grant, g);
      chk("acc_mem_en", mem_en, 1);
      chk("acc_mem_we", mem_we, we);
      chk("acc_mem_addr", mem_addr, a);
      if (we) chk("acc_mem_wdata", mem_wdata, wd);
      chk("acc_busy", busy, 1);
      chk("acc_f_ack", f_ack, 0);
      chk("acc_d_ack", d_ack, 0);
      check_rdata();
      if (i == 1 && mode != 0) begin
        if (fw) f_addr = (mode == 2) ? 16'h0300 : 16'($urandom);
        else begin
          d_addr  = (mode == 2) ? 16'h0300 : 16'($urandom);
          d_wdata = 16'($urandom);
          d_we    = 1'($urandom);
        end
        if (mode == 2) begin
          if (fw) f_req = 1'b0;
          else    d_req = 1'b0;
        end
      end
    end
    if (we)      ref_mem[a[11:0]] = wd;
    else if (fw) exp_f = ref_mem[a[11:0]];
    else         exp_d = ref_mem[a[11:0]];
    @(negedge clk);
    chk("done_f_ack", f_ack, fw);
    chk("done_d_ack", d_ack, !fw);
    chk("done_mem_en", mem_en, 0);
    chk("done_mem_we", mem_we, 0);
    chk("done_grant", grant, g);
    chk("done_busy", busy, 1);
    check_rdata();
    if (we) chk("mem_written", mem[a[11:0]], wd);
    last_ack_cyc = cyc;
    if (fw) f_req = 1'b0;
    else    d_req = 1'b0;
    @(negedge clk);
    check_quiet("idle");
    chk("idle_mem_addr", mem_addr, a);
    check_rdata();
  endtask

  task automatic model_reset();
    m_last_data = 1'b1;
    exp_f = '0;
    exp_d = '0;
  endtask

  initial begin
    int unsigned s, a1;
    bit fp, dp, fw;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    rst = 1'b1;
    f_req = 0; f_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    model_reset();

    // Reset state, before and after a clock edge
    #1;
    check_quiet("rst0");
    chk("rst0_mem_addr", mem_addr, 0);
    chk("rst0_mem_wdata", mem_wdata, 0);
    check_rdata();
    @(negedge clk);
    check_quiet("rst1");
    rst = 1'b0;

    // Data read after reset, with latency check
    d_req = 1; d_we = 0; d_addr = 16'h0040;
    s = cyc;
    expect_access(fetch_wins(f_req, d_req), 16'h0040, '0, 0, 0);
    chk("d_read_latency", last_ack_cyc, s + W + 1);
    chk("d_read_value", d_rdata, 16'hBEEF);

    // Single fetch
    f_req = 1; f_addr = 16'h0100;
    expect_access(fetch_wins(f_req, d_req), 16'h0100, '0, 0, 0);
    chk("f_read_value", f_rdata, 16'h1234);

    // Contention right after reset: fetch first, then data
    rst = 1'b1;
    #1;
    check_quiet("rst2");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_rdata();
    f_req = 1; f_addr = 16'h0100;
    d_req = 1; d_we = 0; d_addr = 16'h0040;
    chk("contend_first_fetch", fetch_wins(1, 1), 1);
    expect_access(1, 16'h0100, '0, 0, 0);
    a1 = last_ack_cyc;
    expect_access(fetch_wins(f_req, d_req), 16'h0040, '0, 0, 0);
    chk("ack_spacing", last_ack_cyc - a1, W + 2);

    // Data write leaves d_rdata alone
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'hCAFE;
    expect_access(0, 16'h0200, 16'hCAFE, 1, 0);
    chk("write_keeps_d_rdata", d_rdata, 16'hBEEF);

    // Read back with address change and request drop mid-access
    d_req = 1; d_we = 0; d_addr = 16'h0200;
    expect_access(0, 16'h0200, '0, 0, 2);
    chk("readback_cafe", d_rdata, 16'hCAFE);

    // Reset during the first access cycle
    d_req = 1; d_we = 0; d_addr = 16'h0040;
    @(negedge clk);
    chk("pre_rst_mem_en", mem_en, 1);
    chk("pre_rst_grant", grant, 2'b10);
    #1 rst = 1'b1;
    #1;
    check_quiet("async_rst");
    f_req = 1; f_addr = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("held_rst");
    end
    rst = 1'b0;
    model_reset();
    check_rdata();
    expect_access(fetch_wins(f_req, d_req), 16'h0100, '0, 0, 0);
    expect_access(fetch_wins(f_req, d_req), 16'h0040, '0, 0, 0);

    // Randomized traffic
    fp = 0; dp = 0;
    for (int it = 0; it < 300; it++) begin
      if (!fp && $urandom_range(0, 1) == 1) begin
        fp = 1; f_req = 1;
        f_addr = 16'h0F00 | 16'($urandom_range(0, 15));
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; d_req = 1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 16'h0F00 | 16'($urandom_range(0, 15));
        d_wdata = 16'($urandom);
      end
      if (!fp && !dp) begin
        @(negedge clk);
        check_quiet("rand_idle");
      end else begin
        fw = fetch_wins(fp, dp);
        if (fw) begin
          expect_access(1, f_addr, '0, 0, int'($urandom_range(0, 1)));
          fp = 0;
        end else begin
          expect_access(0, d_addr, d_wdata, d_we, int'($urandom_range(0, 1)));
          dp = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
